// File: rtl/clock_advance_scheduler.sv
// Round-robin scheduler that lends a single gated emulation clock to one requester
// at a time, holding run_en high for the requested number of cycles.
module clock_advance_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*CNT_W-1:0]    req_count,
  input  logic                        abort,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          done,
  output logic                        aborted,
  output logic                        run_en,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  active_id,
  output logic [CNT_W-1:0]            remaining
);

  // state | meaning
  // IDLE  | arbitrating; req_ready offered to the round-robin winner
  // RUN   | run_en high, remaining counts down to 1
  // DONE  | one-cycle done pulse to the owner, aborted qualifies it

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              ab_q, ab_d;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   idx;
  logic [CNT_W-1:0]  win_cnt;

  // search starts just after the last owner so every requester gets a turn
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign win_cnt = req_count[int'(win_id)*CNT_W +: CNT_W];

  always_comb begin
    req_ready = '0;
    if (!reset && state_q == IDLE && win_found)
      req_ready[win_id] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    ab_d    = ab_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          id_d = win_id;
          rr_d = win_id;
          ab_d = 1'b0;
          if (win_cnt != '0) begin
            state_d = RUN;
            rem_d   = win_cnt;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = DONE;
          ab_d    = 1'b1;
          rem_d   = '0;
        end else if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        id_d    = '0;
        ab_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        id_d    = '0;
        rem_d   = '0;
        ab_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      rr_q    <= ID_W'(NUM_REQ - 1);
      rem_q   <= '0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
      ab_q    <= ab_d;
    end
  end

  always_comb begin
    done = '0;
    if (state_q == DONE)
      done[id_q] = 1'b1;
  end

  assign run_en    = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign aborted   = ab_q;
  assign active_id = id_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_clock_advance_scheduler.sv
// Scoreboard bench for clock_advance_scheduler: expected completions are queued as
// requests are driven and retired when done pulses appear.
module tb_clock_advance_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_count;
  logic             abort;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     done;
  logic             aborted;
  logic             run_en;
  logic             busy;
  logic [1:0]       active_id;
  logic [W-1:0]     remaining;

  clock_advance_scheduler #(.NUM_REQ(N), .CNT_W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_count (req_count),
    .abort     (abort),
    .req_ready (req_ready),
    .done      (done),
    .aborted   (aborted),
    .run_en    (run_en),
    .busy      (busy),
    .active_id (active_id),
    .remaining (remaining)
  );

  always #5 clock = ~clock;

  typedef struct {
    int id;
    int runs;
    int ab;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int id, input int runs, input int ab);
    exp_t e;
    e.id = id; e.runs = runs; e.ab = ab;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input int c);
    req_count[i*W +: W] = W'(c);
    req_valid[i]        = 1'b1;
  endtask

  task automatic wait_hs(output int id, output int c);
    id = -1;
    c  = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < N; i++)
          if (req_valid[i] && req_ready[i]) id = i;
        c = cyc;
        return;
      end
    end
    chk("hs_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (!busy) begin
        c = cyc;
        return;
      end
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  // monitor: per-cycle invariants, remaining countdown, done retirement
  int run_cnt = 0;
  int exp_rem = 0;
  int own_id  = 0;
  int hs_cyc  = 0;

  always @(negedge clock) begin
    if (reset) begin
      run_cnt = 0;
      exp_rem = 0;
    end else begin
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      chk("done_onehot", 32'($countones(done) <= 1), 1);
      if (run_en) begin
        chk("remaining", remaining, exp_rem);
        if (exp_rem > 0) exp_rem--;
        run_cnt++;
      end else begin
        chk("rem_zero", remaining, 0);
      end
      chk("active_id", active_id, busy ? own_id : 0);
      if (|done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_id", done, 32'(1) << e.id);
          chk("run_cycles", run_cnt, e.runs);
          chk("aborted", aborted, e.ab);
          chk("done_latency", cyc - hs_cyc, e.runs + 1);
        end
        run_cnt = 0;
      end else begin
        chk("aborted_idle", aborted, 0);
      end
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < N; i++)
          if (req_valid[i] && req_ready[i]) begin
            own_id  = i;
            exp_rem = int'(req_count[i*W +: W]);
          end
        hs_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int id, c0, c1, ci;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    reset = 1'b1; req_valid = '0; req_count = '0; abort = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_run_en", run_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_active_id", active_id, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_ready", req_ready, 0);

    // T1: single advance of 3; count changes after the handshake are ignored
    @(posedge clock); #1;
    push(0, 3, 0); set_req(0, 3);
    wait_hs(id, c0);
    chk("t1_id", id, 0);
    @(posedge clock); #1 req_valid[0] = 1'b0; req_count[0 +: W] = W'(99);
    wait_idle(ci);
    chk("t1_idle_cyc", ci - c0, 5);

    // T2: req0 beats req2 straight after reset, req2 granted 3 cycles later
    do_reset();
    push(0, 1, 0); push(2, 1, 0);
    set_req(0, 1); set_req(2, 1);
    wait_hs(id, c0);
    chk("t2_first", id, 0);
    @(posedge clock); #1 req_valid[0] = 1'b0;
    wait_hs(id, c1);
    chk("t2_second", id, 2);
    chk("t2_gap", c1 - c0, 3);
    @(posedge clock); #1 req_valid[2] = 1'b0;
    wait_idle(ci);

    // T3: everyone valid, rotation 0,1,2,3,0 at one grant per 3 cycles
    do_reset();
    for (int i = 0; i < 5; i++) push(order[i], 1, 0);
    for (int i = 0; i < N; i++) set_req(i, 1);
    c0 = -1;
    for (int k = 0; k < 5; k++) begin
      wait_hs(id, c1);
      chk("t3_order", id, order[k]);
      if (k > 0) chk("t3_gap", c1 - c0, 3);
      c0 = c1;
    end
    @(posedge clock); #1 req_valid = '0;
    wait_idle(ci);

    // T4: zero-length advance goes straight to DONE
    @(posedge clock); #1;
    push(1, 0, 0); set_req(1, 0);
    wait_hs(id, c0);
    chk("t4_id", id, 1);
    @(posedge clock); #1 req_valid[1] = 1'b0;
    wait_idle(ci);
    chk("t4_idle_cyc", ci - c0, 2);

    // T5: abort in the second RUN cycle
    @(posedge clock); #1;
    push(3, 2, 1); set_req(3, 10);
    wait_hs(id, c0);
    chk("t5_id", id, 3);
    @(posedge clock); #1 req_valid[3] = 1'b0;
    @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    wait_idle(ci);
    chk("t5_idle_cyc", ci - c0, 4);

    // abort while idle has no effect
    @(posedge clock); #1 abort = 1'b1;
    @(negedge clock);
    chk("idle_abort_busy", busy, 0);
    @(posedge clock); #1 abort = 1'b0;

    // T6: reset in the middle of RUN kills the advance without a done pulse
    @(posedge clock); #1;
    set_req(2, 8);
    wait_hs(id, c0);
    chk("t6_id", id, 2);
    @(posedge clock); #1 req_valid[2] = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("t6_run_en", run_en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_remaining", remaining, 0);
    chk("t6_done", done, 0);
    @(posedge clock); #1;
    push(1, 1, 0); push(2, 1, 0);
    set_req(1, 1); set_req(2, 1);
    wait_hs(id, c0);
    chk("t6_first", id, 1);
    @(posedge clock); #1 req_valid[1] = 1'b0;
    wait_hs(id, c1);
    chk("t6_second", id, 2);
    @(posedge clock); #1 req_valid[2] = 1'b0;
    wait_idle(ci);

    repeat (3) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
